act_writeback: RTL and testbench

- Writeback/operand end of the PE accumulate pipeline. Owns the output-activation register file.
- Commits `comp_en_wb`/`out_act_addr_wb`/`add_result_wb` from the add stage.
- Supplies the read-modify-write operand `out_act_value_add` back to the add stage, with full forwarding for back-to-back same-address accumulates.
- At layer end, drains all activations over a valid/ready stream and clears them for the next layer.

---
 rtl/act_writeback_pkg.sv | 19 +
 rtl/act_writeback_if.sv | 34 +++
 rtl/act_writeback_out_act_rf.sv | 31 +++
 rtl/act_writeback.sv | 123 ++++++++++++
 tb/tb_act_writeback.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/act_writeback_pkg.sv
// rtl/act_writeback_pkg.sv - shared widths, sizes and drain state encodings for the writeback stage
package act_writeback_pkg;

  localparam int DATA_W  = 16;
  localparam int ACT_NUM = 16;
  localparam int ADDR_W  = $clog2(ACT_NUM);

  typedef logic [DATA_W-1:0] pe_data_t;
  typedef logic [ADDR_W-1:0] pe_act_no_t;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_DRAIN = 2'd1,
    WB_DONE  = 2'd2
  } wb_state_e;

  localparam pe_act_no_t LAST_ACT = pe_act_no_t'(ACT_NUM - 1);

endpackage

// File: rtl/act_writeback_if.sv
// rtl/act_writeback_if.sv - writeback, operand and drain stream signals of the writeback stage
interface act_writeback_if;
  import act_writeback_pkg::*;

  logic       comp_en_wb;
  pe_act_no_t out_act_addr_wb;
  pe_data_t   add_result_wb;
  logic       comp_en_rd;
  pe_act_no_t out_act_addr_rd;
  pe_data_t   out_act_value_add;
  logic       layer_done;
  logic       act_out_valid;
  logic       act_out_ready;
  pe_act_no_t act_out_addr;
  pe_data_t   act_out_data;
  logic       busy;
  logic       drain_done;
  logic       wr_err;

  modport master (
    output comp_en_wb, out_act_addr_wb, add_result_wb, comp_en_rd, out_act_addr_rd,
           layer_done, act_out_ready,
    input  out_act_value_add, act_out_valid, act_out_addr, act_out_data, busy,
           drain_done, wr_err
  );

  modport slave (
    input  comp_en_wb, out_act_addr_wb, add_result_wb, comp_en_rd, out_act_addr_rd,
           layer_done, act_out_ready,
    output out_act_value_add, act_out_valid, act_out_addr, act_out_data, busy,
           drain_done, wr_err
  );

endinterface

// File: rtl/act_writeback_out_act_rf.sv
// rtl/act_writeback_out_act_rf.sv - output-activation flop array, one write port, two async read ports
module act_writeback_out_act_rf
  import act_writeback_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  pe_act_no_t waddr,
  input  pe_data_t   wdata,
  input  pe_act_no_t op_addr,
  output pe_data_t   op_data,
  input  pe_act_no_t drain_addr,
  output pe_data_t   drain_data
);

  pe_data_t mem [ACT_NUM];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ACT_NUM; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign op_data    = mem[op_addr];
  assign drain_data = mem[drain_addr];

endmodule

// File: rtl/act_writeback.sv
// rtl/act_writeback.sv - PE accumulate writeback: RF commit, forwarded operand read, layer-end drain
module act_writeback
  import act_writeback_pkg::*;
(
  input logic            clk,
  input logic            rst,
  act_writeback_if.slave bus
);

  wb_state_e  state;
  pe_act_no_t cnt;
  pe_act_no_t rd_addr_q;
  pe_data_t   rd_data_q;
  logic       act_out_valid_q;
  logic       busy_q;
  logic       drain_done_q;
  logic       wr_err_q;

  logic       wr_commit;
  logic       beat;
  logic       rf_we;
  pe_act_no_t rf_waddr;
  pe_data_t   rf_wdata;
  pe_data_t   rf_op_data;
  pe_data_t   rf_drain_data;

  // Compute writes are dropped while draining; forwarding follows the same rule.
  assign wr_commit = bus.comp_en_wb && (state != WB_DRAIN);
  assign beat      = (state == WB_DRAIN) && bus.act_out_ready;

  always_comb begin
    rf_we    = wr_commit;
    rf_waddr = bus.out_act_addr_wb;
    rf_wdata = bus.add_result_wb;
    if (beat) begin
      rf_we    = 1'b1;
      rf_waddr = cnt;
      rf_wdata = '0;
    end
  end

  act_writeback_out_act_rf u_rf (
    .clk        (clk),
    .rst        (rst),
    .we         (rf_we),
    .waddr      (rf_waddr),
    .wdata      (rf_wdata),
    .op_addr    (bus.out_act_addr_rd),
    .op_data    (rf_op_data),
    .drain_addr (cnt),
    .drain_data (rf_drain_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else if (bus.comp_en_rd) begin
      rd_addr_q <= bus.out_act_addr_rd;
      rd_data_q <= (wr_commit && (bus.out_act_addr_wb == bus.out_act_addr_rd))
                   ? bus.add_result_wb : rf_op_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= WB_IDLE;
      cnt             <= '0;
      act_out_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      drain_done_q    <= 1'b0;
      wr_err_q        <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      if (bus.comp_en_wb && (state == WB_DRAIN)) begin
        wr_err_q <= 1'b1;
      end
      case (state)
        WB_IDLE: begin
          if (bus.layer_done) begin
            state           <= WB_DRAIN;
            cnt             <= '0;
            act_out_valid_q <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        WB_DRAIN: begin
          if (bus.act_out_ready) begin
            if (cnt == LAST_ACT) begin
              state           <= WB_DONE;
              act_out_valid_q <= 1'b0;
              busy_q          <= 1'b0;
              drain_done_q    <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WB_DONE: begin
          state <= WB_IDLE;
          cnt   <= '0;
        end
        default: begin
          state           <= WB_IDLE;
          cnt             <= '0;
          act_out_valid_q <= 1'b0;
          busy_q          <= 1'b0;
        end
      endcase
    end
  end

  // Distance-1 forwarding: register followed by a single mux.
  assign bus.out_act_value_add = (wr_commit && (bus.out_act_addr_wb == rd_addr_q))
                                 ? bus.add_result_wb : rd_data_q;
  assign bus.act_out_valid     = act_out_valid_q;
  assign bus.act_out_addr      = cnt;
  assign bus.act_out_data      = rf_drain_data;
  assign bus.busy              = busy_q;
  assign bus.drain_done        = drain_done_q;
  assign bus.wr_err            = wr_err_q;

endmodule

// File: tb/tb_act_writeback.sv
// tb/tb_act_writeback.sv - randomized scoreboard bench for act_writeback
module tb_act_writeback;
  import act_writeback_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  act_writeback_if b ();

  act_writeback dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // Reference model: array contents plus a count of beats still owed by the drain.
  logic [15:0] m_rf [16];
  int          drain_left = 0;
  bit          done_next  = 1'b0;
  bit          m_wr_err   = 1'b0;
  int          done_exp   = 0;
  bit          pend_rd    = 1'b0;
  logic [3:0]  pend_addr  = '0;

  logic [15:0] op_q [$];
  logic [19:0] beat_q [$];

  bit exp_busy = 1'b0, exp_done = 1'b0, exp_wr_err = 1'b0;
  bit chk_on = 1'b0, chk_op0 = 1'b0, final_chk = 1'b0;

  int n_chk = 0, n_fail = 0, done_cnt = 0;
  bit rd_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_prev <= rst && b.comp_en_rd;

  always @(negedge clk) begin
    if (b.drain_done === 1'b1) done_cnt++;
    if (chk_on && rst) begin
      chk("busy", 32'(b.busy), 32'(exp_busy));
      chk("act_out_valid", 32'(b.act_out_valid), 32'(exp_busy));
      chk("drain_done", 32'(b.drain_done), 32'(exp_done));
      chk("wr_err", 32'(b.wr_err), 32'(exp_wr_err));
      if (b.act_out_valid === 1'b1) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          chk("act_out_addr", 32'(b.act_out_addr), 32'(beat_q[0][19:16]));
          chk("act_out_data", 32'(b.act_out_data), 32'(beat_q[0][15:0]));
          if (b.act_out_ready) void'(beat_q.pop_front());
        end
      end
      if (rd_prev) begin
        if (op_q.size() == 0) chk("operand_missing_expect", 32'd1, 32'd0);
        else chk("out_act_value_add", 32'(b.out_act_value_add), 32'(op_q.pop_front()));
      end
      if (chk_op0) chk("reset_operand", 32'(b.out_act_value_add), 32'd0);
    end
    if (final_chk) begin
      chk("drain_done_count", 32'(done_cnt), 32'(done_exp));
      chk("beats_outstanding", 32'(beat_q.size()), 32'd0);
      chk("operands_outstanding", 32'(op_q.size()), 32'd0);
    end
  end

  task automatic cycle(input bit we, input logic [3:0] wa, input logic [15:0] wd,
                       input bit re, input logic [3:0] ra, input bit ld, input bit rdy);
    bit in_done;
    @(posedge clk); #1;
    rst = 1'b1; chk_on = 1'b1; chk_op0 = 1'b0;
    b.comp_en_wb = we; b.out_act_addr_wb = wa; b.add_result_wb = wd;
    b.comp_en_rd = re; b.out_act_addr_rd = ra;
    b.layer_done = ld; b.act_out_ready = rdy;
    exp_busy = (drain_left > 0); exp_done = done_next; exp_wr_err = m_wr_err;
    in_done = done_next;
    done_next = 1'b0;
    if (we) begin
      if (drain_left > 0) m_wr_err = 1'b1;
      else m_rf[wa] = wd;
    end
    // An operand reflects every write committed up to the cycle it is consumed in.
    if (pend_rd) op_q.push_back(m_rf[pend_addr]);
    pend_rd = re; pend_addr = ra;
    if (drain_left > 0) begin
      if (rdy) begin
        drain_left--;
        if (drain_left == 0) begin
          done_next = 1'b1;
          done_exp++;
        end
      end
    end else if (ld && !in_done) begin
      for (int i = 0; i < 16; i++) begin
        beat_q.push_back({4'(i), m_rf[i]});
        m_rf[i] = '0;
      end
      drain_left = 16;
    end
  endtask

  task automatic reset_cycle();
    @(posedge clk); #1;
    rst = 1'b0; chk_on = 1'b0; chk_op0 = 1'b0;
    b.comp_en_wb = 1'b0; b.out_act_addr_wb = '0; b.add_result_wb = '0;
    b.comp_en_rd = 1'b0; b.out_act_addr_rd = '0; b.layer_done = 1'b0; b.act_out_ready = 1'b0;
    for (int i = 0; i < 16; i++) m_rf[i] = '0;
    drain_left = 0; done_next = 1'b0; m_wr_err = 1'b0; pend_rd = 1'b0;
    beat_q.delete(); op_q.delete();
  endtask

  task automatic idle();
    cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'(a), 1'b0, 1'b0);
    idle();
  endtask

  task automatic random_writes(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    b.comp_en_wb = 1'b0; b.out_act_addr_wb = '0; b.add_result_wb = '0;
    b.comp_en_rd = 1'b0; b.out_act_addr_rd = '0; b.layer_done = 1'b0; b.act_out_ready = 1'b0;
    reset_cycle();
    reset_cycle();
    idle();
    chk_op0 = 1'b1;
    idle();

    // Plain write then read.
    cycle(1'b1, 4'd3, 16'h0010, 1'b0, 4'd0, 1'b0, 1'b0);
    idle();
    cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 1'b0, 1'b0);
    idle();
    // Distance-1 hazard.
    cycle(1'b1, 4'd5, 16'h0004, 1'b0, 4'd0, 1'b0, 1'b0);
    idle();
    cycle(1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 1'b0, 1'b0);
    cycle(1'b1, 4'd5, 16'h0009, 1'b0, 4'd0, 1'b0, 1'b0);
    // Distance-2 hazard.
    cycle(1'b1, 4'd7, 16'h0021, 1'b1, 4'd7, 1'b0, 1'b0);
    idle();

    // Random accumulate traffic, biased toward a few addresses to provoke forwarding.
    for (int i = 0; i < 400; i++) begin
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      cycle(1'($urandom), 4'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 15)), 16'($urandom),
            1'($urandom), 4'(narrow ? $urandom_range(0, 3) : $urandom_range(0, 15)), 1'b0, 1'b0);
    end
    idle();

    // Drain with alternating backpressure and a dropped write mid-drain.
    for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 16'(i + 1), 1'b0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 80 && drain_left > 0; k++)
      cycle(k == 2, 4'd2, 16'h00FF, 1'b0, 4'd0, 1'b0, (k % 2) == 0);
    idle();
    idle();
    read_all();

    // Reset in the middle of a drain.
    random_writes(8);
    cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    reset_cycle();
    idle();
    read_all();

    // Drain under random backpressure, with a write in the same cycle as layer_done.
    random_writes(20);
    cycle(1'b1, 4'd9, 16'hBEEF, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 0; k < 300 && drain_left > 0; k++)
      cycle(1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 1'b0, 1'($urandom));
    cycle(1'b1, 4'd4, 16'h1234, 1'b0, 4'd0, 1'b0, 1'b0);
    idle();
    read_all();

    idle();
    final_chk = 1'b1;
    @(negedge clk); #1;
    final_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
